// File: rtl/spram_req_ctrl.sv
// ============================================================================
// Module  : spram_req_ctrl
// Brief   : Request/response front end for a single-port RAM with a shared
//           bidirectional data bus and one cycle of read latency.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spram_req_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  wr_cnt,
  output logic [CNT_WIDTH-1:0]  rd_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_ADDR = 2'd2,
    RD_DATA = 2'd3
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  w_accept;

  assign req_ready = (r_state == IDLE) && (!rsp_valid || rsp_ready);
  assign w_accept  = req_valid && req_ready;
  assign busy      = (r_state != IDLE);

  // ram_we is only set in WR and oe is never set there, so the bus has one owner
  assign ram_data = ram_we ? r_wdata : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_wdata   <= '0;
      ram_addr  <= '0;
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_oe    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            ram_addr <= req_addr;
            r_wdata  <= req_wdata;
            ram_cs   <= 1'b1;
            ram_we   <= req_we;
            ram_oe   <= 1'b0;
            r_state  <= req_we ? WR : RD_ADDR;
          end
        end
        WR: begin
          ram_cs  <= 1'b0;
          ram_we  <= 1'b0;
          if (wr_cnt != {CNT_WIDTH{1'b1}}) begin
            wr_cnt <= wr_cnt + 1'b1;
          end
          r_state <= IDLE;
        end
        RD_ADDR: begin
          ram_oe  <= 1'b1;
          r_state <= RD_DATA;
        end
        RD_DATA: begin
          ram_cs    <= 1'b0;
          ram_oe    <= 1'b0;
          rsp_rdata <= ram_data;
          rsp_valid <= 1'b1;
          if (rd_cnt != {CNT_WIDTH{1'b1}}) begin
            rd_cnt <= rd_cnt + 1'b1;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spram_req_ctrl.sv
// ============================================================================
// Module  : tb_spram_req_ctrl
// Brief   : Scoreboard bench for spram_req_ctrl with a behavioural RAM model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spram_req_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
  logic [3:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, rsp_valid, ram_cs, ram_we, ram_oe, busy;
  logic [31:0] rsp_rdata;
  logic [3:0]  ram_addr;
  wire  [31:0] ram_data;
  logic [15:0] wr_cnt, rd_cnt;

  // narrow-counter instance, write traffic only
  logic        req_valid2 = 1'b0;
  logic        req_ready2, rsp_valid2, ram_cs2, ram_we2, ram_oe2, busy2;
  logic [31:0] rsp_rdata2;
  logic [3:0]  ram_addr2;
  wire  [31:0] ram_data2;
  logic [1:0]  wr_cnt2, rd_cnt2;

  int n_chk = 0, n_pass = 0, n_bad_strobe = 0;
  logic [31:0] ref_mem [16];
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  spram_req_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_cs(ram_cs), .ram_we(ram_we),
    .ram_oe(ram_oe), .busy(busy), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
  );

  spram_req_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_we(1'b1), .req_addr(4'd2), .req_wdata(32'h5A5A_0000),
    .rsp_valid(rsp_valid2), .rsp_ready(1'b1), .rsp_rdata(rsp_rdata2),
    .ram_addr(ram_addr2), .ram_data(ram_data2), .ram_cs(ram_cs2), .ram_we(ram_we2),
    .ram_oe(ram_oe2), .busy(busy2), .wr_cnt(wr_cnt2), .rd_cnt(rd_cnt2)
  );

  // RAM model: stores on cs&we, latches mem[addr] on cs&!we, drives bus on cs&oe&!we
  logic [31:0] ram_mem [16];
  logic [31:0] ram_q;
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) ram_mem[ram_addr] <= ram_data;
      else        ram_q <= ram_mem[ram_addr];
    end
  end
  assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_q : 32'hzzzz_zzzz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // accept and response monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_oe && ram_we) n_bad_strobe++;
      if (req_valid && req_ready) begin
        if (req_we) ref_mem[req_addr] = req_wdata;
        else        sb.push_back(ref_mem[req_addr]);
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
        else chk("rsp_rdata", rsp_rdata, sb.pop_front());
      end
    end
  end

  // caller sits just after a posedge; returns just after the accepting posedge
  task automatic send(input logic we, input logic [3:0] a, input logic [31:0] d);
    bit ok = 1'b0;
    req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (sb.size() != 0 || busy); i++) begin
      @(posedge clk); #1;
    end
    chk("drain_pending", sb.size(), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", ram_cs, 0);
    chk("rst_we_oe", {ram_we, ram_oe}, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_cnts", {wr_cnt, rd_cnt}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ram_addr", ram_addr, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_req_ready", req_ready, 1);

    // write then read one word, checking read latency
    send(1'b1, 4'd3, 32'hDEAD_BEEF);
    chk("wr_strobes", {ram_cs, ram_we, ram_oe}, 32'b110);
    send(1'b0, 4'd3, 32'h0);
    @(negedge clk); chk("lat_edge1", rsp_valid, 0);
    chk("rd_addr_strobes", {ram_cs, ram_we, ram_oe}, 32'b100);
    @(negedge clk); chk("lat_edge2", rsp_valid, 0);
    chk("rd_data_strobes", {ram_cs, ram_we, ram_oe}, 32'b101);
    @(negedge clk); chk("lat_edge3", rsp_valid, 1);
    @(posedge clk); #1;
    drain();
    chk("t1_cnts", {wr_cnt, rd_cnt}, {16'd1, 16'd1});

    // reset in the middle of a read drops it
    send(1'b0, 4'd3, 32'h0);
    chk("rd_addr_busy", busy, 1);
    rst_n = 1'b0; #1;
    sb.delete();
    chk("arst_strobes", {ram_cs, ram_we, ram_oe}, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    chk("arst_no_rsp", {rsp_valid, rd_cnt}, 0);

    // full-range writes then reads in order
    for (int a = 0; a < 16; a++) send(1'b1, a[3:0], a * 32'h0101_0101);
    for (int a = 0; a < 16; a++) send(1'b0, a[3:0], 32'h0);
    drain();
    chk("t2_wr_cnt", wr_cnt, 16);
    chk("t2_rd_cnt", rd_cnt, 16);

    // response back-pressure
    rsp_ready = 1'b0;
    send(1'b0, 4'd5, 32'h0);
    for (int i = 0; i < 20 && !rsp_valid; i++) begin @(posedge clk); #1; end
    held = rsp_rdata;
    chk("bp_first_data", held, 32'h0505_0505);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_rdata", rsp_rdata, held);
      chk("bp_req_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req_we = 1'b1; req_addr = 4'd9; req_wdata = 32'h1234_5678; req_valid = 1'b1;
    @(negedge clk); chk("bp_release_ready", req_ready, 1);
    @(posedge clk); #1; req_valid = 1'b0;
    drain();

    // back-to-back write/read on the same address
    send(1'b1, 4'd7, 32'hCAFE_F00D);
    send(1'b0, 4'd7, 32'h0);
    send(1'b1, 4'd7, 32'h0BAD_C0DE);
    send(1'b0, 4'd7, 32'h0);
    drain();
    chk("no_oe_we_overlap", n_bad_strobe, 0);

    // saturating 2-bit counter
    for (int i = 0; i < 5; i++) begin
      req_valid2 = 1'b1;
      for (int j = 0; j < 10; j++) begin
        @(negedge clk);
        if (req_ready2) break;
      end
      @(posedge clk); #1;
      req_valid2 = 1'b0;
    end
    repeat (3) begin @(posedge clk); #1; end
    chk("sat_wr_cnt", wr_cnt2, 3);
    chk("sat_rd_cnt", rd_cnt2, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
